// File: rtl/benchmark1_word_collector.sv
// benchmark1_word_collector
// Deserialises the qualified single-bit stream from the benchmark1 datapath
// into WORD_W-bit words (first bit received lands in the MSB) and buffers
// completed words in a show-ahead FIFO with a valid/ready output handshake.
// A flush pushes a partial word left-aligned and zero-padded. overflow is
// sticky and records any word dropped because the FIFO was full.
//
// Optional feature macro: COLLECTOR_PARITY_EN
//   When defined, every FIFO entry also carries the XOR parity of its word,
//   computed at push time, and the word_parity output presents the head
//   entry's parity (0 while empty).

module benchmark1_word_collector #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    input  logic                          flush,
    output logic [WORD_W-1:0]             word_out,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow
`ifdef COLLECTOR_PARITY_EN
    ,
    output logic                          word_parity
`endif
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
`ifdef COLLECTOR_PARITY_EN
    localparam int ENT_W = WORD_W + 1;
`else
    localparam int ENT_W = WORD_W;
`endif

    // Bit count that marks a complete word, held one bit wider than cnt so
    // that "cnt after taking this cycle's bit" can reach WORD_W.
    localparam logic [CNT_W:0] WORD_FULL = (CNT_W + 1)'(WORD_W);

    // Assembly state
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // FIFO state
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];

    // Intermediate signals
    logic [WORD_W-1:0] sr_after;
    logic [CNT_W:0]    cnt_after;
    logic              push_req;
    logic [WORD_W-1:0] push_word;
    logic [ENT_W-1:0]  push_entry;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push_ok;
    logic [ENT_W-1:0]  head_entry;

    // Take this cycle's bit first, then decide whether a completed or
    // flushed word is pushed and where the bit counter goes next.
    always_comb begin
        // NOTE: every variable assigned here gets a default on entry so no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        sr_after  = sr_q;
        cnt_after = {1'b0, cnt_q};
        if (bit_valid) begin
            sr_after  = {sr_q[WORD_W-2:0], bit_in};
            cnt_after = cnt_after + 1'b1;
        end

        sr_d      = sr_after;
        cnt_d     = cnt_after[CNT_W-1:0];
        push_req  = 1'b0;
        push_word = sr_after;

        if (cnt_after == WORD_FULL) begin
            // A completing bit wins over flush: only the normal push occurs.
            push_req = 1'b1;
            cnt_d    = '0;
        end else if (flush && (cnt_after != '0)) begin
            // The partial word occupies the low cnt_after bits of the shift
            // register; shifting left drops stale upper bits and zero-pads.
            push_req  = 1'b1;
            push_word = sr_after << (WORD_FULL - cnt_after);
            cnt_d     = '0;
        end
    end

    // FIFO occupancy, handshake and the push/pop/overflow decision.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                     (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
        pop        = !fifo_empty && word_ready;
        // A pop in the same cycle frees the slot the push needs, so a full
        // FIFO still accepts the word.
        push_ok    = push_req && (!fifo_full || pop);

        wr_ptr_d   = wr_ptr_q + {{IDX_W{1'b0}}, push_ok};
        rd_ptr_d   = rd_ptr_q + {{IDX_W{1'b0}}, pop};
        overflow_d = overflow_q || (push_req && !push_ok);

`ifdef COLLECTOR_PARITY_EN
        push_entry = {^push_word, push_word};
`else
        push_entry = push_word;
`endif
    end

    // Assembly and FIFO control registers with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of block order.
        if (!reset_n) begin
            sr_q       <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clock) begin
        // NOTE: the storage array is deliberately not reset; an entry is only
        // visible between its write and its pop, and outputs are masked to 0
        // while the FIFO is empty, so reset pointers alone give clean state.
        if (push_ok) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= push_entry;
        end
    end

    // Show-ahead head presentation, masked to zero while empty.
    always_comb begin
        head_entry = mem_q[rd_ptr_q[IDX_W-1:0]];
        word_valid = !fifo_empty;
        word_out   = fifo_empty ? '0 : head_entry[WORD_W-1:0];
        fill_level = wr_ptr_q - rd_ptr_q;
        overflow   = overflow_q;
`ifdef COLLECTOR_PARITY_EN
        word_parity = fifo_empty ? 1'b0 : head_entry[WORD_W];
`endif
    end

endmodule
